// File: rtl/lb_rr_arbiter_if.sv
// Requester and local-bus signal bundle for lb_rr_arbiter.
// The arbiter takes the slave view; the requesters and peripheral side take the master view.
interface lb_rr_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m0_req;
   logic          m0_wr;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_done;
   logic [DW-1:0] m0_rdata;
   logic          m0_err;
   logic          m1_req;
   logic          m1_wr;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_done;
   logic [DW-1:0] m1_rdata;
   logic          m1_err;
   logic          lb_cs;
   logic          lb_wrout;
   logic [AW-1:0] lb_aout;
   logic [DW-1:0] lb_dout;
   logic          lb_rdyh;
   logic [DW-1:0] lb_din;
   logic          busy;
   logic          owner;

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_wdata,
      output m0_done, m0_rdata, m0_err,
      input  m1_req, m1_wr, m1_addr, m1_wdata,
      output m1_done, m1_rdata, m1_err,
      output lb_cs, lb_wrout, lb_aout, lb_dout,
      input  lb_rdyh, lb_din,
      output busy, owner
   );

   modport master (
      output m0_req, m0_wr, m0_addr, m0_wdata,
      input  m0_done, m0_rdata, m0_err,
      output m1_req, m1_wr, m1_addr, m1_wdata,
      input  m1_done, m1_rdata, m1_err,
      input  lb_cs, lb_wrout, lb_aout, lb_dout,
      output lb_rdyh, lb_din,
      input  busy, owner
   );
endinterface

// File: rtl/lb_rr_arbiter.sv
// Two-requester round-robin sequencer for the register local bus,
// one access at a time, with a completion timeout.
module lb_rr_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int TO_CYCLES = 16,
   parameter int TOW       = 5
) (
   input logic                pclk,
   input logic                preset_n,
   lb_rr_arbiter_if.slave     bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                owner_q, owner_d;
   logic [TOW-1:0]      cnt_q, cnt_d;
   logic                cs_q, cs_d;
   logic                wr_q, wr_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DW-1:0]       data_q, data_d;
   logic [1:0]          done_q, done_d;
   logic [1:0]          err_q, err_d;
   logic [1:0][DW-1:0]  rdata_q, rdata_d;
   logic                gnt1;
   logic                tmo;

   // m1 wins when alone, or on contention when m0 held the last grant
   assign gnt1 = bus.m1_req & (~bus.m0_req | ~owner_q);
   assign tmo  = (cnt_q == TOW'(TO_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      cs_d    = cs_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = done_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.m0_req | bus.m1_req) begin
               owner_d = gnt1;
               cs_d    = 1'b1;
               cnt_d   = '0;
               wr_d    = gnt1 ? bus.m1_wr    : bus.m0_wr;
               addr_d  = gnt1 ? bus.m1_addr  : bus.m0_addr;
               data_d  = gnt1 ? bus.m1_wdata : bus.m0_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (bus.lb_rdyh) begin
               rdata_d[owner_q] = wr_q ? '0 : bus.lb_din;
               done_d[owner_q]  = 1'b1;
               err_d[owner_q]   = 1'b0;
               cs_d    = 1'b0;
               state_d = DONE;
            end else if (tmo) begin
               rdata_d[owner_q] = '0;
               done_d[owner_q]  = 1'b1;
               err_d[owner_q]   = 1'b1;
               cs_d    = 1'b0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            done_d  = '0;
            err_d   = '0;
            rdata_d = '0;
            state_d = IDLE;
         end
         default: begin
            cs_d    = 1'b0;
            done_d  = '0;
            err_d   = '0;
            rdata_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q <= IDLE;
         owner_q <= 1'b1;
         cnt_q   <= '0;
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.lb_cs    = cs_q;
   assign bus.lb_wrout = wr_q;
   assign bus.lb_aout  = addr_q;
   assign bus.lb_dout  = data_q;
   assign bus.m0_done  = done_q[0];
   assign bus.m1_done  = done_q[1];
   assign bus.m0_err   = err_q[0];
   assign bus.m1_err   = err_q[1];
   assign bus.m0_rdata = rdata_q[0];
   assign bus.m1_rdata = rdata_q[1];
   assign bus.busy     = (state_q != IDLE);
   assign bus.owner    = owner_q;
endmodule

// File: tb/tb_lb_rr_arbiter.sv
// Randomized bench for lb_rr_arbiter against a transaction-level
// round-robin model (pending requests, last owner, response delay).
module tb_lb_rr_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic pclk = 1'b0;
   logic preset_n = 1'b0;
   always #5 pclk = ~pclk;

   lb_rr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   lb_rr_arbiter #(
      .AW(AW), .DW(DW), .TO_CYCLES(TO), .TOW(5)
   ) dut (
      .pclk(pclk),
      .preset_n(preset_n),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   bit            pend [2];
   bit            wr_m [2];
   logic [AW-1:0] ad_m [2];
   logic [DW-1:0] wd_m [2];
   int            last;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      bus.m0_req   = pend[0];
      bus.m0_wr    = wr_m[0];
      bus.m0_addr  = ad_m[0];
      bus.m0_wdata = wd_m[0];
      bus.m1_req   = pend[1];
      bus.m1_wr    = wr_m[1];
      bus.m1_addr  = ad_m[1];
      bus.m1_wdata = wd_m[1];
   endtask

   task automatic set_req(input int i, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i] = 1'b1;
      wr_m[i] = w;
      ad_m[i] = a;
      wd_m[i] = d;
   endtask

   // scramble the granted requester's inputs mid-access
   task automatic mutate(input int w);
      if (w == 0) begin
         bus.m0_addr  = ~ad_m[0];
         bus.m0_wdata = $urandom;
         bus.m0_wr    = ~wr_m[0];
         bus.m0_req   = 1'b0;
      end else begin
         bus.m1_addr  = ~ad_m[1];
         bus.m1_wdata = $urandom;
         bus.m1_wr    = ~wr_m[1];
         bus.m1_req   = 1'b0;
      end
   endtask

   // d: access cycle index (0-based) on which lb_rdyh is raised
   task automatic run_round(input int d, input bit mut);
      int            w;
      int            k;
      int            cs_n;
      bit            fin;
      bit            rdy;
      logic [DW-1:0] din_s;
      logic [DW-1:0] exp_rd;
      logic [DW-1:0] rd_w;
      logic [DW-1:0] rd_o;
      @(negedge pclk);
      apply();
      bus.lb_rdyh = 1'b0;
      if (pend[0] && pend[1]) w = 1 - last;
      else w = pend[0] ? 0 : 1;
      @(posedge pclk);
      #1;
      chk("grant_cs", bus.lb_cs, 1);
      chk("grant_owner", bus.owner, w);
      chk("grant_wr", bus.lb_wrout, wr_m[w]);
      chk("grant_addr", bus.lb_aout, ad_m[w]);
      chk("grant_wdata", bus.lb_dout, wd_m[w]);
      chk("grant_busy", bus.busy, 1);
      cs_n  = 1;
      fin   = 0;
      k     = 0;
      rdy   = 0;
      din_s = '0;
      while (!fin) begin
         @(negedge pclk);
         if (mut) mutate(w);
         bus.lb_rdyh = (k == d);
         bus.lb_din  = $urandom;
         rdy   = (k == d);
         din_s = bus.lb_din;
         @(posedge pclk);
         #1;
         if (rdy || k == TO - 1) begin
            fin = 1;
         end else begin
            chk("hold_cs", bus.lb_cs, 1);
            chk("hold_addr", bus.lb_aout, ad_m[w]);
            chk("hold_done", {bus.m1_done, bus.m0_done}, 0);
            cs_n++;
         end
         k++;
      end
      chk("cs_cycles", cs_n, (d < TO) ? d + 1 : TO);
      exp_rd = (rdy && !wr_m[w]) ? din_s : '0;
      rd_w = (w == 0) ? bus.m0_rdata : bus.m1_rdata;
      rd_o = (w == 0) ? bus.m1_rdata : bus.m0_rdata;
      chk("done_vec", {bus.m1_done, bus.m0_done}, (w == 0) ? 2'b01 : 2'b10);
      chk("err_vec", {bus.m1_err, bus.m0_err},
          rdy ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10));
      chk("rdata_own", rd_w, exp_rd);
      chk("rdata_other", rd_o, 0);
      chk("done_cs", bus.lb_cs, 0);
      @(negedge pclk);
      pend[w] = 1'b0;
      apply();
      bus.lb_rdyh = 1'b0;
      @(posedge pclk);
      #1;
      chk("idle_done", {bus.m1_done, bus.m0_done, bus.m1_err, bus.m0_err}, 0);
      chk("idle_rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
      chk("idle_busy", bus.busy, 0);
      last = w;
   endtask

   initial begin
      pend = '{0, 0};
      wr_m = '{0, 0};
      ad_m = '{0, 0};
      wd_m = '{0, 0};
      last = 1;
      apply();
      bus.lb_rdyh = 1'b0;
      bus.lb_din  = '0;
      #12;
      chk("rst_cs", bus.lb_cs, 0);
      chk("rst_owner", bus.owner, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", {bus.m1_done, bus.m0_done, bus.m1_err, bus.m0_err}, 0);
      chk("rst_bus", {bus.lb_wrout, bus.lb_aout, bus.lb_dout}, 0);
      @(negedge pclk);
      preset_n = 1'b1;

      // single write, immediate ready
      set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
      run_round(0, 0);
      // m1 read with a 3-cycle peripheral delay
      set_req(1, 1'b0, 32'h24, 32'h0);
      run_round(3, 0);
      // timeout, then ready exactly on the last allowed cycle
      set_req(0, 1'b0, 32'h30, 32'h0);
      run_round(TO, 0);
      set_req(1, 1'b0, 32'h34, 32'h0);
      run_round(TO - 1, 0);
      // inputs changed mid-access are ignored
      set_req(0, 1'b1, 32'h10, 32'h1234_5678);
      run_round(4, 1);
      // persistent contention alternates grants
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i]) set_req(i, 1'($urandom), $urandom, $urandom);
         run_round($urandom_range(0, 2), 0);
      end

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 2) != 0)
               set_req(i, 1'($urandom), $urandom, $urandom);
         if (!pend[0] && !pend[1])
            set_req($urandom_range(0, 1), 1'($urandom), $urandom, $urandom);
         run_round(($urandom_range(0, 3) == 0) ? $urandom_range(10, 20)
                                               : $urandom_range(0, 5),
                   $urandom_range(0, 3) == 0);
      end

      // reset during an access, with m1 waiting
      pend = '{0, 0};
      set_req(0, 1'b0, 32'h40, 32'h0);
      @(negedge pclk);
      apply();
      @(posedge pclk);
      #1;
      chk("rstacc_cs", bus.lb_cs, 1);
      @(negedge pclk);
      pend[0] = 1'b0;
      set_req(1, 1'b1, 32'h44, 32'hCAFE_0044);
      apply();
      #2;
      preset_n = 1'b0;
      #1;
      chk("rstacc_cs_drop", bus.lb_cs, 0);
      chk("rstacc_busy", bus.busy, 0);
      chk("rstacc_owner", bus.owner, 1);
      @(posedge pclk);
      #1;
      chk("rstacc_done", {bus.m1_done, bus.m0_done}, 0);
      @(posedge pclk);
      #2;
      preset_n = 1'b1;
      last = 1;
      run_round(1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
